// File: rtl/execute_alu_muldiv_pkg.sv
// Shared types and constants for the ALU / multiply-divide execute stage.
package execute_alu_muldiv_pkg;

    localparam int XLEN    = 32;
    localparam int MD_ITER = 32;
    localparam int SPEC_W  = 6;
    localparam int TAG_W   = 6;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        MULDIV = 2'd1,
        LSU    = 2'd2,
        BRU    = 2'd3
    } unit_t;

    typedef enum logic [1:0] {
        EX_NORMAL   = 2'd0,
        EX_GEN_ADDR = 2'd1,
        EX_MEM      = 2'd2,
        EX_BRANCH   = 2'd3
    } ex_mode_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Op = {funct7, funct3}
    typedef struct packed {
        logic              is_valid;
        unit_t             unit;
        ex_mode_t          mode;
        logic [9:0]        op;
        logic [XLEN-1:0]   vj;
        logic [XLEN-1:0]   vk;
        tag_t              tag;
        logic [SPEC_W-1:0] speculative_tag;
    } ex_content_t;

    typedef struct packed {
        logic              is_valid;
        tag_t              tag;
        ex_mode_t          mode;
        logic [SPEC_W-1:0] speculative_tag;
        logic [XLEN-1:0]   value;
    } result_t;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    // An entry dies when a flush names any of its speculation bits.
    function automatic logic slot_killed(input logic [SPEC_W-1:0] spec,
                                         input logic              flush,
                                         input logic [SPEC_W-1:0] mask);
        return flush && (|(spec & mask));
    endfunction

endpackage

// File: rtl/execute_alu_muldiv_if.sv
// Issue/result bundle between wakeup-select, this execute stage and the ROB/CDB.
interface execute_alu_muldiv_if;
    import execute_alu_muldiv_pkg::*;

    ex_content_t [1:0] ex_contents;
    logic              flush;
    logic [SPEC_W-1:0] flush_mask;
    logic [1:0]        accepted;
    result_t [1:0]     alu_results;
    result_t           md_result;
    logic              md_busy;

    modport master (
        output ex_contents, flush, flush_mask,
        input  accepted, alu_results, md_result, md_busy
    );

    modport slave (
        input  ex_contents, flush, flush_mask,
        output accepted, alu_results, md_result, md_busy
    );
endinterface

// File: rtl/execute_alu_muldiv_muldiv_iter.sv
// Shared iterative multiply/divide unit: shift-add multiply, restoring divide.
module muldiv_iter
    import execute_alu_muldiv_pkg::*;
#(
    parameter int ITERS = MD_ITER
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        start_funct3,
    input  logic [XLEN-1:0]   start_a,
    input  logic [XLEN-1:0]   start_b,
    input  tag_t              start_tag,
    input  logic [SPEC_W-1:0] start_spec,
    input  logic              flush,
    input  logic [SPEC_W-1:0] flush_mask,
    output logic              ready,
    output logic              busy,
    output result_t           result
);
    localparam int CNT_W = $clog2(ITERS) + 1;

    md_state_t         state;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   operand;
    logic [2:0]        funct3;
    tag_t              tag;
    logic [SPEC_W-1:0] spec;
    logic              neg_a;
    logic              neg_b;
    logic              b_zero;

    logic              start_neg_a;
    logic              start_neg_b;
    logic [XLEN-1:0]   start_mag_a;
    logic [XLEN-1:0]   start_mag_b;
    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              kill;

    assign ready = (state != MD_RUN);
    assign busy  = (state == MD_RUN);
    assign kill  = slot_killed(spec, flush, flush_mask);

    // Signed operands enter the datapath as magnitudes; the signs are kept aside.
    always_comb begin
        start_neg_a = start_a[XLEN-1] &&
                      (start_funct3 == F3_MUL || start_funct3 == F3_MULH ||
                       start_funct3 == F3_MULHSU || start_funct3 == F3_DIV ||
                       start_funct3 == F3_REM);
        start_neg_b = start_b[XLEN-1] &&
                      (start_funct3 == F3_MUL || start_funct3 == F3_MULH ||
                       start_funct3 == F3_DIV || start_funct3 == F3_REM);
        start_mag_a = start_neg_a ? -start_a : start_a;
        start_mag_b = start_neg_b ? -start_b : start_b;
    end

    // One radix-2 step: add-and-shift-right for multiply, shift-and-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        rem_shift = {hi, lo[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, operand};
        hi_next   = mul_sum[XLEN:1];
        lo_next   = {mul_sum[0], lo[XLEN-1:1]};
        if (funct3[2]) begin
            if (!rem_diff[XLEN]) begin
                hi_next = rem_diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = rem_shift[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and result selection, presented only during DONE unless flushed.
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
        quot_fix = ((neg_a ^ neg_b) && !b_zero) ? -lo : lo;
        rem_fix  = neg_a ? -hi : hi;
        result   = '0;
        if (state == MD_DONE && !kill) begin
            result.is_valid        = 1'b1;
            result.tag             = tag;
            result.mode            = EX_NORMAL;
            result.speculative_tag = spec;
            case (funct3)
                F3_MUL:                    result.value = prod_fix[XLEN-1:0];
                F3_MULH, F3_MULHSU,
                F3_MULHU:                  result.value = prod_fix[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:           result.value = quot_fix;
                default:                   result.value = rem_fix;
            endcase
        end
    end

    // FSM and datapath registers; DONE can take a new op back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MD_IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            operand <= '0;
            funct3  <= '0;
            tag     <= '0;
            spec    <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            b_zero  <= 1'b0;
        end else if (start && state != MD_RUN) begin
            state   <= MD_RUN;
            count   <= '0;
            hi      <= '0;
            lo      <= start_funct3[2] ? start_mag_a : start_mag_b;
            operand <= start_funct3[2] ? start_mag_b : start_mag_a;
            funct3  <= start_funct3;
            tag     <= start_tag;
            spec    <= start_spec;
            neg_a   <= start_neg_a;
            neg_b   <= start_neg_b;
            b_zero  <= (start_b == '0);
        end else begin
            case (state)
                MD_RUN: begin
                    if (kill) begin
                        state <= MD_IDLE;
                    end else begin
                        hi    <= hi_next;
                        lo    <= lo_next;
                        count <= count + 1'b1;
                        if (count == CNT_W'(ITERS - 1)) begin
                            state <= MD_DONE;
                        end
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_alu_muldiv.sv
// Execute stage: two single-cycle ALU lanes plus one shared iterative mul/div unit.
module execute_alu_muldiv
    import execute_alu_muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    execute_alu_muldiv_if.slave  bus
);
    logic [1:0]    alu_take;
    logic [1:0]    md_class;
    logic          md_take0;
    logic          md_take1;
    logic          md_ready;
    ex_content_t   md_slot;
    result_t [1:0] alu_reg;

    function automatic logic [XLEN-1:0] alu_compute(input ex_content_t s);
        logic [4:0] shamt;
        logic       alt;
        shamt = s.vk[4:0];
        alt   = s.op[8];
        if (s.mode == EX_GEN_ADDR) begin
            return s.vj + s.vk;
        end
        case (s.op[2:0])
            F3_ADD_SUB: return alt ? s.vj - s.vk : s.vj + s.vk;
            F3_SLL:     return s.vj << shamt;
            F3_SLT:     return {{(XLEN-1){1'b0}}, $signed(s.vj) < $signed(s.vk)};
            F3_SLTU:    return {{(XLEN-1){1'b0}}, s.vj < s.vk};
            F3_XOR:     return s.vj ^ s.vk;
            F3_SRL_SRA: return alt ? $unsigned($signed(s.vj) >>> shamt) : s.vj >> shamt;
            F3_OR:      return s.vj | s.vk;
            default:    return s.vj & s.vk;
        endcase
    endfunction

    // Classify each slot and grant the mul/div unit to the first MD slot when free.
    always_comb begin
        alu_take = '0;
        md_class = '0;
        for (int i = 0; i < 2; i++) begin
            if (bus.ex_contents[i].is_valid &&
                !slot_killed(bus.ex_contents[i].speculative_tag, bus.flush, bus.flush_mask)) begin
                alu_take[i] = (bus.ex_contents[i].unit == ALU) ||
                              (bus.ex_contents[i].mode == EX_GEN_ADDR);
                md_class[i] = (bus.ex_contents[i].unit == MULDIV) &&
                              (bus.ex_contents[i].mode == EX_NORMAL);
            end
        end
        md_take0     = md_ready && md_class[0];
        md_take1     = md_ready && md_class[1] && !md_class[0];
        md_slot      = md_take1 ? bus.ex_contents[1] : bus.ex_contents[0];
        bus.accepted = alu_take | {md_take1, md_take0};
    end

    // Lane results are registered one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_reg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (alu_take[i]) begin
                    alu_reg[i].is_valid        <= 1'b1;
                    alu_reg[i].tag             <= bus.ex_contents[i].tag;
                    alu_reg[i].mode            <= bus.ex_contents[i].mode;
                    alu_reg[i].speculative_tag <= bus.ex_contents[i].speculative_tag;
                    alu_reg[i].value           <= alu_compute(bus.ex_contents[i]);
                end else begin
                    alu_reg[i] <= '0;
                end
            end
        end
    end

    // A flush arriving while a lane result is visible suppresses it.
    always_comb begin
        bus.alu_results = alu_reg;
        for (int i = 0; i < 2; i++) begin
            if (slot_killed(alu_reg[i].speculative_tag, bus.flush, bus.flush_mask)) begin
                bus.alu_results[i].is_valid = 1'b0;
            end
        end
    end

    muldiv_iter #(.ITERS(MD_ITER)) u_muldiv (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (md_take0 | md_take1),
        .start_funct3 (md_slot.op[2:0]),
        .start_a      (md_slot.vj),
        .start_b      (md_slot.vk),
        .start_tag    (md_slot.tag),
        .start_spec   (md_slot.speculative_tag),
        .flush        (bus.flush),
        .flush_mask   (bus.flush_mask),
        .ready        (md_ready),
        .busy         (bus.md_busy),
        .result       (bus.md_result)
    );

endmodule
